// File: rtl/sd_bus_sampler.sv
// sd_bus_sampler: oversamples the SD CLK/CMD/DAT pins in the core clock domain.
// The SD CLK is synchronized and glitch-filtered into rise/fall strobes. CMD/DAT
// are captured at each filtered rise, the SD CLK period is measured, and loss
// of SD CLK is flagged.
//   i_clk, i_rst          core clock, async active-high reset
//   i_sd_clk/cmd/dat      raw asynchronous SD pins
//   o_rise, o_fall        one-cycle filtered edge strobes
//   o_cmd, o_dat          CMD/DAT sampled at the last rise
//   o_period(_valid)      i_clk cycles between the last two rises
//   o_active              SD CLK present
module sd_bus_sampler #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT        = 2,
  parameter int unsigned PERIOD_W    = 16,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sd_clk,
  input  logic                i_sd_cmd,
  input  logic [3:0]          i_sd_dat,
  output logic                o_rise,
  output logic                o_fall,
  output logic                o_cmd,
  output logic [3:0]          o_dat,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_period_valid,
  output logic                o_active
);

  localparam int unsigned DW  = 5;
  localparam int unsigned FCW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [PERIOD_W-1:0] CYC_MAX = '1;
  localparam logic [PERIOD_W-1:0] CYC_TO  = PERIOD_W'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [DW-1:0]          r_dat_sync [SYNC_STAGES];
  logic                   w_clk_s;
  logic [DW-1:0]          w_dat_s;
  logic [DW-1:0]          w_tap;

  logic                   r_level;
  logic [FCW-1:0]         r_fcnt;
  logic [FCW-1:0]         w_fcnt_next;
  logic                   w_toggle;
  logic                   w_rise;
  logic                   w_fall;

  state_t                 r_state, w_state_next;
  logic [PERIOD_W-1:0]    r_cyc, w_cyc_next;
  logic [PERIOD_W-1:0]    r_period, w_period_next;
  logic                   r_valid, w_valid_next;
  logic                   r_active, w_active_next;
  logic                   r_rise, r_fall;
  logic [DW-1:0]          r_cap;

  // Identical synchronizer chains keep CLK and data pins aligned
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_dat_sync[i] <= '0;
    end else begin
      r_clk_sync    <= {r_clk_sync[SYNC_STAGES-2:0], i_sd_clk};
      r_dat_sync[0] <= {i_sd_cmd, i_sd_dat};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_dat_sync[i] <= r_dat_sync[i-1];
    end
  end

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  // Tap = data seen alongside the first differing CLK sample (FILT-1 cycles back)
  if (FILT == 1) begin : g_tap_direct
    assign w_tap = w_dat_s;
  end else begin : g_tap_dly
    logic [DW-1:0] r_dly [FILT-1];
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int unsigned i = 0; i < FILT-1; i++) r_dly[i] <= '0;
      end else begin
        r_dly[0] <= w_dat_s;
        for (int unsigned i = 1; i < FILT-1; i++) r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_tap = r_dly[FILT-2];
  end

  // Glitch filter: level follows the synced CLK only after FILT agreeing samples
  always_comb begin
    w_toggle    = 1'b0;
    w_fcnt_next = '0;
    if (w_clk_s != r_level) begin
      if (r_fcnt == FCW'(FILT-1)) w_toggle = 1'b1;
      else                        w_fcnt_next = r_fcnt + FCW'(1);
    end
  end

  assign w_rise = w_toggle & ~r_level;
  assign w_fall = w_toggle &  r_level;

  // Next state, period/watchdog counter and reported measurement
  always_comb begin
    w_state_next  = r_state;
    w_active_next = r_active;
    w_period_next = r_period;
    w_valid_next  = r_valid;
    w_cyc_next    = (r_cyc == CYC_MAX) ? r_cyc : r_cyc + PERIOD_W'(1);
    if (w_rise) w_cyc_next = PERIOD_W'(1);
    case (r_state)
      ST_IDLE: begin
        w_valid_next = 1'b0;
        if (w_rise) begin
          w_state_next  = ST_ACTIVE;
          w_active_next = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // A rise on the timeout cycle takes priority over declaring loss
        if (w_rise) begin
          w_period_next = r_cyc;
          w_valid_next  = 1'b1;
        end else if (r_cyc >= CYC_TO) begin
          w_state_next  = ST_IDLE;
          w_active_next = 1'b0;
          w_valid_next  = 1'b0;
        end
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_active_next = 1'b0;
        w_valid_next  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_level  <= 1'b0;
      r_fcnt   <= '0;
      r_cyc    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_active <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cap    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_level  <= r_level ^ w_toggle;
      r_fcnt   <= w_fcnt_next;
      r_cyc    <= w_cyc_next;
      r_period <= w_period_next;
      r_valid  <= w_valid_next;
      r_active <= w_active_next;
      r_rise   <= w_rise;
      r_fall   <= w_fall;
      if (w_rise) r_cap <= w_tap;
    end
  end

  assign o_rise         = r_rise;
  assign o_fall         = r_fall;
  assign o_cmd          = r_cap[4];
  assign o_dat          = r_cap[3:0];
  assign o_period       = r_period;
  assign o_period_valid = r_valid;
  assign o_active       = r_active;

endmodule

// File: tb/tb_sd_bus_sampler.sv
// Bench for sd_bus_sampler (SYNC_STAGES=2, FILT=2, TIMEOUT=16).
module tb_sd_bus_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sd_clk, sd_cmd;
  logic [3:0]  sd_dat;
  logic        rise, fall, ocmd, pvalid, active;
  logic [3:0]  odat;
  logic [15:0] period;

  int n_checks = 0;
  int n_errors = 0;

  sd_bus_sampler #(.SYNC_STAGES(2), .FILT(2), .PERIOD_W(16), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_sd_clk(sd_clk), .i_sd_cmd(sd_cmd), .i_sd_dat(sd_dat),
    .o_rise(rise), .o_fall(fall), .o_cmd(ocmd), .o_dat(odat), .o_period(period),
    .o_period_valid(pvalid), .o_active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clk;
    logic        cmd;
    logic [3:0]  dat;
    logic        rise;
    logic        fall;
    logic        ocmd;
    logic [3:0]  odat;
    logic        act;
    logic        vld;
    logic [15:0] per;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input int idx, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, idx, act_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sd_clk = 1'b0; sd_cmd = 1'b0; sd_dat = 4'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rise"}, 0, 32'(rise), 32'd0);
    chk({nm, "_fall"}, 0, 32'(fall), 32'd0);
    chk({nm, "_cmd"}, 0, 32'(ocmd), 32'd0);
    chk({nm, "_dat"}, 0, 32'(odat), 32'd0);
    chk({nm, "_per"}, 0, 32'(period), 32'd0);
    chk({nm, "_vld"}, 0, 32'(pvalid), 32'd0);
    chk({nm, "_act"}, 0, 32'(active), 32'd0);
  endtask

  function automatic vec_t mk(input logic c, input logic m, input logic [3:0] d,
                              input logic r, input logic f, input logic oc, input logic [3:0] od,
                              input logic a, input logic v, input logic [15:0] p);
    vec_t t;
    t.clk = c; t.cmd = m; t.dat = d; t.rise = r; t.fall = f; t.ocmd = oc;
    t.odat = od; t.act = a; t.vld = v; t.per = p;
    return t;
  endfunction

  initial begin
    // Rise latency, tap alignment, fall strobe, glitch rejection, DAT hold, second rise period
    tbl[0] = mk(1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 2; i++)
      tbl[i] = mk(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
    tbl[3] = mk(1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 16'd0);
    tbl[4] = mk(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 16'd0);
    for (int i = 5; i <= 7; i++)
      tbl[i] = mk(1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 16'd0);
    tbl[8] = mk(1'b0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 16'd0);
    tbl[9] = mk(1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 16'd0);
    tbl[10] = mk(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 16'd0);
    for (int i = 11; i <= 14; i++)
      tbl[i] = mk(1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 16'd0);
    for (int i = 15; i <= 17; i++)
      tbl[i] = mk(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 16'd0);
    tbl[18] = mk(1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 16'd15);
    tbl[19] = mk(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 16'd15);

    do_reset();
    chk_all_zero("reset");

    for (int i = 0; i < 20; i++) begin
      sd_clk = tbl[i].clk; sd_cmd = tbl[i].cmd; sd_dat = tbl[i].dat;
      step();
      chk("tbl_rise", i, 32'(rise), 32'(tbl[i].rise));
      chk("tbl_fall", i, 32'(fall), 32'(tbl[i].fall));
      chk("tbl_cmd", i, 32'(ocmd), 32'(tbl[i].ocmd));
      chk("tbl_dat", i, 32'(odat), 32'(tbl[i].odat));
      chk("tbl_act", i, 32'(active), 32'(tbl[i].act));
      chk("tbl_vld", i, 32'(pvalid), 32'(tbl[i].vld));
      chk("tbl_per", i, 32'(period), 32'(tbl[i].per));
    end

    // 8-cycle square wave, CMD toggles on falling edges, then clock stops -> timeout
    do_reset();
    for (int n = 0; n < 56; n++) begin
      sd_clk = (n < 40) && ((n % 8) < 4);
      if ((n % 8) == 4) sd_cmd = ~sd_cmd;
      step();
      chk("sq_rise", n, 32'(rise), 32'((n >= 3) && (n <= 35) && ((n - 3) % 8 == 0)));
      chk("sq_fall", n, 32'(fall), 32'((n >= 7) && (n <= 39) && ((n - 7) % 8 == 0)));
      chk("sq_act", n, 32'(active), 32'((n >= 3) && (n < 51)));
      chk("sq_vld", n, 32'(pvalid), 32'((n >= 11) && (n < 51)));
      chk("sq_per", n, 32'(period), (n >= 11) ? 32'd8 : 32'd0);
      if ((n >= 3) && (n <= 35) && ((n - 3) % 8 == 0))
        chk("sq_cmd", n, 32'(ocmd), 32'(((n - 3) / 8) % 2));
    end

    // Second rise lands exactly on the timeout cycle: rise wins
    do_reset();
    for (int n = 0; n < 20; n++) begin
      sd_clk = (n < 4) || (n >= 16);
      step();
      if (n == 3)  chk("tw_rise1", n, 32'(rise), 32'd1);
      if (n == 18) chk("tw_act_pre", n, 32'(active), 32'd1);
      if (n == 19) begin
        chk("tw_rise2", n, 32'(rise), 32'd1);
        chk("tw_act", n, 32'(active), 32'd1);
        chk("tw_vld", n, 32'(pvalid), 32'd1);
        chk("tw_per", n, 32'(period), 32'd16);
      end
    end

    // Asynchronous reset mid-cycle, then SD CLK held high through release
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    #1;
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("rr_rise", n, 32'(rise), 32'(n == 3));
      chk("rr_act", n, 32'(active), 32'(n == 3));
      chk("rr_vld", n, 32'(pvalid), 32'd0);
      chk("rr_per", n, 32'(period), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
